// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

  localparam int MIN_DELAY_MS_DEF = 1000;
  localparam int RAND_BITS_DEF    = 12;
  localparam int MAX_COUNT_DEF    = 999999;
  localparam int COUNT_W          = 20;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Feedback taps 16,14,13,11 (1-based) as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_GO   = 3'd2,
    S_DONE = 3'd3,
    S_FOUL = 3'd4
  } state_t;

endpackage

// File: rtl/reaction_lfsr.sv
// Free-running 16-bit Fibonacci LFSR supplying the random part of the wait.
module reaction_lfsr
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  // An all-zero register would lock up; fall back to the seed if it ever appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      value <= LFSR_SEED;
    else if (value == 16'h0000)
      value <= LFSR_SEED;
    else
      value <= {value[14:0], ^(value & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_controller.sv
// Reaction-time game sequencer: random wait, go light, millisecond timer.
//   state | meaning
//   IDLE  | powered up, waiting for start
//   WAIT  | random delay running, led_wait on
//   GO    | led_go on, counting ms until react
//   DONE  | count_ms holds the result
//   FOUL  | react pressed during WAIT
module reaction_controller
  import reaction_pkg::*;
#(
  parameter int MIN_DELAY_MS = MIN_DELAY_MS_DEF,
  parameter int RAND_BITS    = RAND_BITS_DEF,
  parameter int MAX_COUNT    = MAX_COUNT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_ms,
  input  logic               start_btn,
  input  logic               react_btn,
  output logic               led_wait,
  output logic               led_go,
  output logic [COUNT_W-1:0] count_ms,
  output logic               result_valid,
  output logic               false_start
);

  localparam int DELAY_W = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));
  localparam logic [15:0]        RAND_MASK = 16'((32'd1 << RAND_BITS) - 32'd1);
  localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_COUNT);

  localparam logic [2:0] ST_IDLE = 3'(S_IDLE);
  localparam logic [2:0] ST_WAIT = 3'(S_WAIT);
  localparam logic [2:0] ST_GO   = 3'(S_GO);
  localparam logic [2:0] ST_DONE = 3'(S_DONE);
  localparam logic [2:0] ST_FOUL = 3'(S_FOUL);

  logic [15:0]        lfsr;
  logic [2:0]         start_sync;
  logic [2:0]         react_sync;
  logic               start_p;
  logic               react_p;
  logic [2:0]         state_q;
  logic [DELAY_W-1:0] delay_q;
  logic [COUNT_W-1:0] count_q;

  reaction_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  // [0],[1] metastability chain, [2] previous synced level for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= '0;
      react_sync <= '0;
    end else begin
      start_sync <= {start_sync[1:0], start_btn};
      react_sync <= {react_sync[1:0], react_btn};
    end
  end

  assign start_p = start_sync[1] & ~start_sync[2];
  assign react_p = react_sync[1] & ~react_sync[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (react_p) begin
            state_q <= ST_FOUL;
            count_q <= '0;
          end else if (tick_ms) begin
            if (delay_q <= DELAY_W'(1)) begin
              state_q <= ST_GO;
              delay_q <= '0;
              count_q <= '0;
            end else begin
              delay_q <= delay_q - DELAY_W'(1);
            end
          end
        end
        ST_GO: begin
          // react wins over a same-cycle tick so the frozen value is not bumped
          if (react_p)
            state_q <= ST_DONE;
          else if (tick_ms && (count_q < MAX_CNT))
            count_q <= count_q + COUNT_W'(1);
        end
        ST_IDLE, ST_DONE, ST_FOUL: begin
          if (start_p) begin
            state_q <= ST_WAIT;
            delay_q <= DELAY_W'(32'(MIN_DELAY_MS) + 32'(lfsr & RAND_MASK));
            count_q <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          delay_q <= '0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign led_wait     = (state_q == ST_WAIT);
  assign led_go       = (state_q == ST_GO);
  assign result_valid = (state_q == ST_DONE);
  assign false_start  = (state_q == ST_FOUL);
  assign count_ms     = count_q;

endmodule

// File: tb/tb_reaction_controller.sv
// Bench for reaction_controller: default-parameter instance plus a short-timing instance, both checked every cycle against a behavioural model.
module tb_reaction_controller;

  localparam int A_MIN = 1000;
  localparam int A_RB  = 12;
  localparam int A_MAX = 999999;
  localparam int B_MIN = 8;
  localparam int B_RB  = 3;
  localparam int B_MAX = 40;

  localparam int PH_IDLE = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_GO   = 2;
  localparam int PH_DONE = 3;
  localparam int PH_FOUL = 4;

  typedef struct {
    int          phase;
    int          delay;
    int          count;
    logic [15:0] lfsr;
    logic [2:0]  hs;
    logic [2:0]  hr;
  } model_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_ms;
  logic        start_btn;
  logic        react_btn;
  logic        led_wait_a, led_go_a, result_valid_a, false_start_a;
  logic [19:0] count_ms_a;
  logic        led_wait_b, led_go_b, result_valid_b, false_start_b;
  logic [19:0] count_ms_b;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     tick_cnt = 0;
  model_t m_a, m_b;

  reaction_controller u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .tick_ms      (tick_ms),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .led_wait     (led_wait_a),
    .led_go       (led_go_a),
    .count_ms     (count_ms_a),
    .result_valid (result_valid_a),
    .false_start  (false_start_a)
  );

  reaction_controller #(
    .MIN_DELAY_MS (B_MIN),
    .RAND_BITS    (B_RB),
    .MAX_COUNT    (B_MAX)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .tick_ms      (tick_ms),
    .start_btn    (start_btn),
    .react_btn    (react_btn),
    .led_wait     (led_wait_b),
    .led_go       (led_go_b),
    .count_ms     (count_ms_b),
    .result_valid (result_valid_b),
    .false_start  (false_start_b)
  );

  initial forever #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic model_t model_reset();
    model_t m;
    m.phase = PH_IDLE;
    m.delay = 0;
    m.count = 0;
    m.lfsr  = 16'hACE1;
    m.hs    = '0;
    m.hr    = '0;
    return m;
  endfunction

  // A press is seen three edges after the pin rises: act on pin(n-2)=1, pin(n-3)=0.
  function automatic model_t model_step(input model_t m, input logic sb, input logic rb,
                                        input logic tk, input int min_d, input int rbits,
                                        input int maxc);
    model_t n;
    logic   sp, rp;
    n  = m;
    sp = m.hs[1] & ~m.hs[2];
    rp = m.hr[1] & ~m.hr[2];
    case (m.phase)
      PH_WAIT: begin
        if (rp) begin
          n.phase = PH_FOUL;
          n.count = 0;
        end else if (tk) begin
          n.delay = m.delay - 1;
          if (n.delay == 0) begin
            n.phase = PH_GO;
            n.count = 0;
          end
        end
      end
      PH_GO: begin
        if (rp) n.phase = PH_DONE;
        else if (tk && m.count < maxc) n.count = m.count + 1;
      end
      default: begin
        if (sp) begin
          n.phase = PH_WAIT;
          n.delay = min_d + (int'(m.lfsr) % (1 << rbits));
          n.count = 0;
        end
      end
    endcase
    n.hs   = {m.hs[1:0], sb};
    n.hr   = {m.hr[1:0], rb};
    n.lfsr = lfsr_next(m.lfsr);
    return n;
  endfunction

  function automatic logic [31:0] model_out(input model_t m);
    logic [19:0] c;
    c = 20'(m.count);
    return {8'h0, m.phase == PH_WAIT, m.phase == PH_GO, m.phase == PH_DONE, m.phase == PH_FOUL, c};
  endfunction

  function automatic logic [31:0] obs_a();
    return {8'h0, led_wait_a, led_go_a, result_valid_a, false_start_a, count_ms_a};
  endfunction

  function automatic logic [31:0] obs_b();
    return {8'h0, led_wait_b, led_go_b, result_valid_b, false_start_b, count_ms_b};
  endfunction

  // Reference model: advance on every edge, compare just after it.
  initial begin
    m_a = model_reset();
    m_b = model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_a = model_reset();
        m_b = model_reset();
      end else begin
        m_a = model_step(m_a, start_btn, react_btn, tick_ms, A_MIN, A_RB, A_MAX);
        m_b = model_step(m_b, start_btn, react_btn, tick_ms, B_MIN, B_RB, B_MAX);
      end
      #1;
      check_eq("cycle_a", obs_a(), model_out(m_a));
      check_eq("cycle_b", obs_b(), model_out(m_b));
    end
  end

  task automatic step_clk();
    @(negedge clk);
    tick_cnt++;
    tick_ms = (tick_cnt % 4 == 0);
  endtask

  task automatic press_start(input int hold);
    start_btn = 1'b1;
    repeat (hold) step_clk();
    start_btn = 1'b0;
  endtask

  task automatic press_react(input int hold);
    react_btn = 1'b1;
    repeat (hold) step_clk();
    react_btn = 1'b0;
  endtask

  int   found, wt, sel, hold, gap;
  logic w, t, go_seen;

  initial begin
    start_btn = 1'b0;
    react_btn = 1'b0;
    tick_ms   = 1'b0;
    repeat (3) step_clk();
    check_eq("reset_outputs_a", obs_a(), 32'h0);
    check_eq("reset_outputs_b", obs_b(), 32'h0);
    rst = 1'b0;

    press_react(3);
    repeat (6) step_clk();
    check_eq("react_in_idle", obs_a(), 32'h0);

    // Line the start press up so the captured LFSR field is 0x123.
    found = 0;
    for (int i = 0; i < 70000 && found == 0; i++) begin
      if ((lfsr_next(lfsr_next(m_a.lfsr)) & 16'h0FFF) == 16'h0123) found = 1;
      else step_clk();
    end
    check_eq("lfsr_field_0x123", found, 1);
    start_btn = 1'b1;
    wt = 0;
    for (int i = 0; i < 30000 && led_go_a == 1'b0; i++) begin
      w = led_wait_a;
      t = tick_ms;
      step_clk();
      if (w && t) wt++;
      if (i == 4) start_btn = 1'b0;
    end
    start_btn = 1'b0;
    check_eq("wait_ticks", wt, 1291);
    check_eq("go_led", led_go_a, 1);
    check_eq("go_wait_off", led_wait_a, 0);
    check_eq("go_count_zero", count_ms_a, 0);

    // Pressing right after the 250th tick leaves three tick-free edges before DONE.
    for (int i = 0; i < 2000 && count_ms_a != 20'd250; i++) step_clk();
    react_btn = 1'b1;
    repeat (4) step_clk();
    react_btn = 1'b0;
    check_eq("done_valid", result_valid_a, 1);
    check_eq("done_count", count_ms_a, 250);
    check_eq("done_go_off", led_go_a, 0);
    repeat (4000) step_clk();
    check_eq("done_hold_count", count_ms_a, 250);
    check_eq("done_hold_valid", result_valid_a, 1);
    press_react(3);
    repeat (4) step_clk();
    check_eq("react_in_done", obs_a(), {8'h0, 4'b0010, 20'd250});

    press_start(3);
    repeat (40) step_clk();
    check_eq("wait_led", led_wait_a, 1);
    press_start(3);
    repeat (10) step_clk();
    check_eq("start_in_wait", obs_a(), {8'h0, 4'b1000, 20'd0});
    press_react(3);
    repeat (4) step_clk();
    check_eq("foul_during_wait", obs_a(), {8'h0, 4'b0001, 20'd0});

    press_start(3);
    for (int i = 0; i < 400 && led_go_b == 1'b0; i++) step_clk();
    check_eq("b_reaches_go", led_go_b, 1);
    press_start(3);
    repeat (4) step_clk();
    check_eq("start_in_go", led_go_b, 1);
    repeat (240) step_clk();
    check_eq("saturate_count", count_ms_b, B_MAX);
    check_eq("saturate_still_go", led_go_b, 1);
    press_react(3);
    repeat (4) step_clk();
    check_eq("saturate_done", obs_b(), {8'h0, 4'b0010, 20'(B_MAX)});

    // React pulse timed to land on the edge carrying the last wait tick.
    press_start(3);
    found = 0;
    go_seen = 1'b0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      if (m_b.phase == PH_WAIT && m_b.delay == 1 && ((tick_cnt + 2) % 4) == 0) found = 1;
      else begin
        step_clk();
        go_seen = go_seen | led_go_b;
      end
    end
    check_eq("final_tick_aligned", found, 1);
    react_btn = 1'b1;
    repeat (3) begin
      step_clk();
      go_seen = go_seen | led_go_b;
    end
    react_btn = 1'b0;
    repeat (4) begin
      step_clk();
      go_seen = go_seen | led_go_b;
    end
    check_eq("foul_final_tick", obs_b(), {8'h0, 4'b0001, 20'd0});
    check_eq("foul_go_never", go_seen, 0);

    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      if ((lfsr_next(lfsr_next(m_a.lfsr)) & 16'h0FFF) < 16'd64) found = 1;
      else step_clk();
    end
    press_start(3);
    for (int i = 0; i < 10000 && count_ms_a != 20'd500; i++) step_clk();
    check_eq("go_count_500", count_ms_a, 500);
    #2;
    rst = 1'b1;
    start_btn = 1'b1;
    #1;
    check_eq("rst_abort_a", obs_a(), 32'h0);
    check_eq("rst_abort_b", obs_b(), 32'h0);
    step_clk();
    step_clk();
    rst = 1'b0;
    repeat (8) step_clk();
    check_eq("held_start_round", obs_a(), {8'h0, 4'b1000, 20'd0});
    repeat (10) step_clk();
    start_btn = 1'b0;
    repeat (4) step_clk();

    for (int r = 0; r < 150; r++) begin
      sel  = int'($urandom_range(0, 9));
      hold = int'($urandom_range(1, 6));
      gap  = int'($urandom_range(0, 40));
      if (sel == 9) begin
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
      end else begin
        start_btn = (sel <= 3) || (sel == 7);
        react_btn = (sel >= 4 && sel <= 7);
        repeat (hold) step_clk();
        start_btn = 1'b0;
        react_btn = 1'b0;
      end
      repeat (gap) step_clk();
    end
    step_clk();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reaction_controller.md
REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 Parameter MIN_DELAY_MS, default 1000, fixed part of the random wait in ms.
REQ-002 Parameter RAND_BITS, default 12, number of LFSR bits added to MIN_DELAY_MS.
REQ-003 Parameter MAX_COUNT, default 999999, saturation value of count_ms (six display digits).
REQ-004 Port clk  input  1  system clock (CLOCK_50 domain), all state on rising edge.
REQ-005 Port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 Port tick_ms  input  1  one-clk-wide pulse once per millisecond, synchronous to clk.
REQ-007 Port start_btn  input  1  start button level, active-high, asynchronous to clk.
REQ-008 Port react_btn  input  1  reaction button level, active-high, asynchronous to clk.
REQ-009 Port led_wait  output  1  high while waiting for the go signal.
REQ-010 Port led_go  output  1  high while the player must react.
REQ-011 Port count_ms  output  20  reaction time in ms, binary, feeds the BCD/segment stage.
REQ-012 Port result_valid  output  1  high while count_ms holds a finished result.
REQ-013 Port false_start  output  1  high after a press during the wait.

Function
REQ-014 Each button SHALL pass a 2-flop synchronizer, then rising-edge detection producing a one-clk pulse (start_p, react_p); pin-to-pulse latency at most 3 clk.
REQ-015 A 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every clk regardless of state and never reach zero.
REQ-016 States SHALL be IDLE, WAIT, GO, DONE, FOUL; outputs are Moore: led_wait=WAIT, led_go=GO, result_valid=DONE, false_start=FOUL.
REQ-017 IDLE/DONE/FOUL: start_p SHALL go to WAIT, load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear count_ms to 0.
REQ-018 WAIT: delay SHALL decrement by 1 per tick_ms; on the tick taking delay to 0, go to GO with count_ms=0.
REQ-019 WAIT: react_p SHALL go to FOUL, with priority over a same-cycle delay expiry.
REQ-020 GO: count_ms SHALL increment by 1 per tick_ms and saturate at MAX_COUNT (no wrap).
REQ-021 GO: react_p SHALL go to DONE with count_ms frozen; a tick_ms in the same cycle SHALL NOT be counted.
REQ-022 DONE: count_ms SHALL hold until the next start_p; FOUL: count_ms SHALL be 0.
REQ-023 start_p in WAIT or GO SHALL be ignored; react_p in IDLE, DONE, FOUL SHALL be ignored.
REQ-024 Delay counter width SHALL cover MIN_DELAY_MS + 2^RAND_BITS - 1 without overflow.

Reset
REQ-025 rst SHALL asynchronously force state IDLE, all outputs 0, count_ms 0, delay 0, synchronizer/edge flops 0, LFSR to seed 16'hACE1.
REQ-026 Reset asserted mid-round SHALL abort immediately; no pulse or count survives release.
REQ-027 A button held high across reset release SHALL produce exactly one pulse after release.

Structure
REQ-028 Package reaction_pkg SHALL hold the state enum, LFSR seed and tap constants, and default MIN_DELAY_MS/MAX_COUNT.
REQ-029 One sub-module, reaction_lfsr (clk, rst, 16-bit value), SHALL implement REQ-015; synchronizers stay inline.

Verification (tick_ms every 4 clk)
REQ-030 Reset, start pulse, LFSR field = 0x123 -> led_wait for exactly 1291 ticks, then led_go=1, count_ms=0.
REQ-031 In GO, react after 250 ticks -> DONE, result_valid=1, count_ms=250 held for 1000 further ticks.
REQ-032 react during WAIT, and react on the same cycle as final delay tick -> FOUL, false_start=1, count_ms=0, led_go never asserted.
REQ-033 GO with no react, force count near limit -> count_ms stops at 999999, no wrap to 0.
REQ-034 rst asserted in GO with count_ms=500 -> all outputs 0 same cycle; start_btn held through release -> one new round only.
REQ-035 start pulses in WAIT and GO, react pulses in IDLE/DONE -> no state change, count_ms unchanged.
